// File: rtl/eth_tx_pkg.sv
// Shared encodings and default timing for the GMII transmit arbiter.
// Source codes double as the active_src output value.
package eth_tx_pkg;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_ARP  = 2'b01;
  localparam logic [1:0] SRC_ICMP = 2'b10;
  localparam logic [1:0] SRC_UDP  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int IFG_CYC_DEF       = 12;
  localparam int START_TIMEOUT_DEF = 1023;
  localparam int MAX_FRAME_CYC_DEF = 1530;

  localparam int CNT_W = 11;
  localparam int GAP_W = 8;

endpackage

// File: rtl/eth_tx_prio_rr.sv
// Grant selection: ARP has fixed top priority, ICMP and UDP alternate on a tie.
// Purely combinational; the caller owns rr_last.
module eth_tx_prio_rr
  import eth_tx_pkg::*;
(
  input  logic       arp_req,
  input  logic       icmp_req,
  input  logic       udp_req,
  input  logic [1:0] rr_last,
  output logic [1:0] winner
);

  always_comb begin
    winner = SRC_NONE;
    if (arp_req) begin
      winner = SRC_ARP;
    end else if (icmp_req && udp_req) begin
      winner = (rr_last == SRC_ICMP) ? SRC_UDP : SRC_ICMP;
    end else if (icmp_req) begin
      winner = SRC_ICMP;
    end else if (udp_req) begin
      winner = SRC_UDP;
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-level arbiter for the shared GMII TX path (ARP, ICMP, UDP generators).
// Holds a grant for a whole frame, enforces the inter-frame gap, and revokes stuck or overlong owners.
//
// state | meaning
// IDLE  | sampling requests, no owner
// GRANT | owner chosen, waiting for its first tx_en
// SEND  | owner's bytes forwarded to the registered output
// GAP   | output held idle for IFG_CYC cycles
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int IFG_CYC       = IFG_CYC_DEF,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  parameter int MAX_FRAME_CYC = MAX_FRAME_CYC_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       arp_req,
  output logic       arp_gnt,
  input  logic       arp_gmii_tx_en,
  input  logic [7:0] arp_gmii_txd,
  input  logic       icmp_req,
  output logic       icmp_gnt,
  input  logic       icmp_gmii_tx_en,
  input  logic [7:0] icmp_gmii_txd,
  input  logic       udp_req,
  output logic       udp_gnt,
  input  logic       udp_gmii_tx_en,
  input  logic [7:0] udp_gmii_txd,
  output logic       gmii_txd_valid,
  output logic [7:0] gmii_txd_data,
  output logic       busy,
  output logic [1:0] active_src,
  output logic       timeout_err,
  output logic       overlong_err
);

  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LEN_LIM   = CNT_W'(MAX_FRAME_CYC);
  localparam logic [GAP_W-1:0] GAP_LIM   = GAP_W'(IFG_CYC - 1);

  logic [1:0]       state;
  logic [1:0]       gnt_src;
  logic [1:0]       rr_last;
  logic [1:0]       winner;
  logic [CNT_W-1:0] start_cnt;
  logic [CNT_W-1:0] len_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             sel_req;
  logic             sel_tx_en;
  logic [7:0]       sel_txd;

  eth_tx_prio_rr u_prio (
    .arp_req  (arp_req),
    .icmp_req (icmp_req),
    .udp_req  (udp_req),
    .rr_last  (rr_last),
    .winner   (winner)
  );

  // Only the owner's lines are ever looked at; everyone else is masked here.
  always_comb begin
    sel_req   = 1'b0;
    sel_tx_en = 1'b0;
    sel_txd   = 8'h00;
    case (gnt_src)
      SRC_ARP: begin
        sel_req   = arp_req;
        sel_tx_en = arp_gmii_tx_en;
        sel_txd   = arp_gmii_txd;
      end
      SRC_ICMP: begin
        sel_req   = icmp_req;
        sel_tx_en = icmp_gmii_tx_en;
        sel_txd   = icmp_gmii_txd;
      end
      SRC_UDP: begin
        sel_req   = udp_req;
        sel_tx_en = udp_gmii_tx_en;
        sel_txd   = udp_gmii_txd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      gnt_src        <= SRC_NONE;
      rr_last        <= SRC_ICMP;
      start_cnt      <= '0;
      len_cnt        <= '0;
      gap_cnt        <= '0;
      gmii_txd_valid <= 1'b0;
      gmii_txd_data  <= 8'h00;
      timeout_err    <= 1'b0;
      overlong_err   <= 1'b0;
    end else begin
      timeout_err    <= 1'b0;
      overlong_err   <= 1'b0;
      gmii_txd_valid <= 1'b0;
      gmii_txd_data  <= 8'h00;
      case (state)
        ST_IDLE: begin
          if (winner != SRC_NONE) begin
            gnt_src   <= winner;
            start_cnt <= '0;
            state     <= ST_GRANT;
            if (winner != SRC_ARP) rr_last <= winner;
          end
        end
        ST_GRANT: begin
          // The first byte arrives with the tx_en that moves us to SEND, so capture it here.
          if (sel_tx_en) begin
            gmii_txd_valid <= 1'b1;
            gmii_txd_data  <= sel_txd;
            len_cnt        <= CNT_W'(1);
            state          <= ST_SEND;
          end else if (!sel_req) begin
            gnt_src <= SRC_NONE;
            state   <= ST_IDLE;
          end else if (start_cnt >= START_LIM) begin
            gnt_src     <= SRC_NONE;
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (!sel_tx_en) begin
            gnt_src <= SRC_NONE;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else if (len_cnt >= LEN_LIM) begin
            gnt_src      <= SRC_NONE;
            overlong_err <= 1'b1;
            gap_cnt      <= '0;
            state        <= ST_GAP;
          end else begin
            gmii_txd_valid <= 1'b1;
            gmii_txd_data  <= sel_txd;
            len_cnt        <= len_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt >= GAP_LIM) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign arp_gnt    = (gnt_src == SRC_ARP);
  assign icmp_gnt   = (gnt_src == SRC_ICMP);
  assign udp_gnt    = (gnt_src == SRC_UDP);
  assign active_src = gnt_src;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: behavioural source agents, a grant-order model and a byte scoreboard.
// Directed scenarios first, then randomized request mixes.
module tb_eth_tx_arbiter;

  localparam int IFG    = 12;
  localparam int TMO    = 1023;
  localparam int MAXLEN = 1530;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] req_v = 3'b000;
  logic [2:0] ten_v = 3'b000;
  logic [7:0] txd_v [3];
  logic       arp_gnt, icmp_gnt, udp_gnt;
  logic       gmii_txd_valid;
  logic [7:0] gmii_txd_data;
  logic       busy;
  logic [1:0] active_src;
  logic       timeout_err, overlong_err;
  logic [2:0] gnt_v;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit count_only = 1'b0;
  bit abort = 1'b0;
  int exp_d [$];
  int exp_c [$];
  int grant_log [$];
  int vtotal = 0, tcount = 0, ocount = 0;

  // monitor state
  int  rr_m = 2;
  bit  prev_busy = 1'b1;
  logic [2:0] prev_gnt = 3'b000, prev_req = 3'b000;
  bit  prev_valid = 1'b0, in_gap = 1'b0;
  int  run = 0;

  assign gnt_v = {udp_gnt, icmp_gnt, arp_gnt};

  eth_tx_arbiter dut (
    .clk             (clk),
    .resetn          (resetn),
    .arp_req         (req_v[0]),
    .arp_gnt         (arp_gnt),
    .arp_gmii_tx_en  (ten_v[0]),
    .arp_gmii_txd    (txd_v[0]),
    .icmp_req        (req_v[1]),
    .icmp_gnt        (icmp_gnt),
    .icmp_gmii_tx_en (ten_v[1]),
    .icmp_gmii_txd   (txd_v[1]),
    .udp_req         (req_v[2]),
    .udp_gnt         (udp_gnt),
    .udp_gmii_tx_en  (ten_v[2]),
    .udp_gmii_txd    (txd_v[2]),
    .gmii_txd_valid  (gmii_txd_valid),
    .gmii_txd_data   (gmii_txd_data),
    .busy            (busy),
    .active_src      (active_src),
    .timeout_err     (timeout_err),
    .overlong_err    (overlong_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: ARP first, otherwise the ICMP/UDP side not served last. 1=ARP 2=ICMP 3=UDP.
  function automatic int model_pick(input logic [2:0] r, input int last);
    if (r[0]) return 1;
    if (r[1] && r[2]) return (last == 2) ? 3 : 2;
    if (r[1]) return 2;
    if (r[2]) return 3;
    return 0;
  endfunction

  function automatic int src_mask(input int s);
    return (s == 0) ? 0 : (1 << (s - 1));
  endfunction

  always @(negedge clk) begin
    int e, d, c, a;
    if (!resetn) begin
      rr_m       = 2;
      prev_busy  = 1'b1;
      prev_gnt   = 3'b000;
      prev_req   = req_v;
      prev_valid = 1'b0;
      in_gap     = 1'b0;
      run        = 0;
    end else begin
      check("gnt_onehot", int'($countones(gnt_v) <= 1), 1);
      a = gnt_v[0] ? 1 : gnt_v[1] ? 2 : gnt_v[2] ? 3 : 0;
      check("active_src", int'(active_src), a);
      if (prev_gnt == 3'b000 && !prev_busy) begin
        e = model_pick(prev_req, rr_m);
        check("grant_pick", int'(gnt_v), src_mask(e));
        if (e == 2 || e == 3) rr_m = e;
        if (e != 0) grant_log.push_back(e);
      end
      if (gmii_txd_valid) begin
        vtotal++;
        if (mon_en && !count_only) begin
          if (exp_d.size() == 0) begin
            check("spurious_valid", 1, 0);
          end else begin
            d = exp_d.pop_front();
            c = exp_c.pop_front();
            check("byte_data", int'(gmii_txd_data), d);
            check("byte_latency", cyc - c, 1);
          end
        end
      end else if (mon_en) begin
        check("idle_data", int'(gmii_txd_data), 0);
      end
      if (prev_valid && !gmii_txd_valid) begin
        in_gap = 1'b1;
        run    = 0;
      end
      if (in_gap && mon_en) begin
        if (busy) run++;
        else begin
          check("ifg_len", run, IFG);
          in_gap = 1'b0;
        end
      end
      tcount += int'(timeout_err);
      ocount += int'(overlong_err);
      prev_busy  = busy;
      prev_gnt   = gnt_v;
      prev_req   = req_v;
      prev_valid = gmii_txd_valid;
    end
  end

  task automatic agent(input int s, input int len, input int dly, input bit hold,
                       input bit push, output int hcnt);
    int w;
    hcnt = 0;
    repeat (dly) tick();
    req_v[s] = 1'b1;
    w = 0;
    while (!gnt_v[s] && !abort && w < 3000) begin tick(); w++; end
    check("gnt_wait_bound", int'(w < 3000), 1);
    for (int i = 0; i < len; i++) begin
      if (!gnt_v[s] || abort) break;
      ten_v[s] = 1'b1;
      txd_v[s] = 8'($urandom);
      if (push) begin
        exp_d.push_back(int'(txd_v[s]));
        exp_c.push_back(cyc);
      end
      tick();
    end
    ten_v[s] = 1'b0;
    txd_v[s] = 8'h00;
    w = 0;
    while (gnt_v[s] && w < 3000) begin tick(); w++; hcnt++; end
    check("gnt_drop_bound", int'(w < 3000), 1);
    if (!hold) req_v[s] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || gnt_v != 3'b000) && n < 5000) begin tick(); n++; end
    check("idle_bound", int'(n < 5000), 1);
    tick();
    tick();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1, h2, base, n, t0, o0;
    txd_v[0] = 8'h00; txd_v[1] = 8'h00; txd_v[2] = 8'h00;

    // reset state, with a request pending that must not be granted
    req_v = 3'b001;
    repeat (3) tick();
    check("rst_gnt", int'(gnt_v), 0);
    check("rst_valid", int'(gmii_txd_valid), 0);
    check("rst_data", int'(gmii_txd_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_active", int'(active_src), 0);
    check("rst_errs", int'({timeout_err, overlong_err}), 0);
    req_v = 3'b000;
    tick();
    resetn = 1'b1;
    mon_en = 1'b1;
    tick();

    // single UDP frame, 64 bytes
    fork
      agent(2, 64, 0, 1'b0, 1'b1, h0);
      begin tick(); check("udp_gnt_latency", int'(udp_gnt), 1); end
    join
    wait_idle();
    check("udp_busy_after", int'(busy), 0);

    // all three at once: ARP, ICMP, UDP
    grant_log.delete();
    fork
      agent(0, 8 + $urandom_range(0, 8), 0, 1'b0, 1'b1, h0);
      agent(1, 8 + $urandom_range(0, 8), 0, 1'b0, 1'b1, h1);
      agent(2, 8 + $urandom_range(0, 8), 0, 1'b0, 1'b1, h2);
    join
    wait_idle();
    check("prio_count", grant_log.size(), 3);
    for (int i = 0; i < grant_log.size() && i < 3; i++) check("prio_order", grant_log[i], i + 1);

    // ICMP and UDP held continuously, 10-byte frames
    grant_log.delete();
    fork
      for (int k = 0; k < 3; k++) agent(1, 10, 0, k < 2, 1'b1, h1);
      for (int k = 0; k < 3; k++) agent(2, 10, 0, k < 2, 1'b1, h2);
    join
    wait_idle();
    check("rr_count", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size() && i < 6; i++)
      check("rr_alternate", grant_log[i], (i % 2 == 0) ? 2 : 3);

    // ICMP stuck without tx_en; UDP pending behind it
    t0 = tcount;
    fork
      begin
        agent(1, 0, 0, 1'b0, 1'b1, h1);
        check("timeout_gnt_cycles", h1, TMO);
        tick();
        check("timeout_next_udp", int'(udp_gnt), 1);
      end
      begin
        repeat (5) tick();
        agent(2, 8, 0, 1'b0, 1'b1, h2);
      end
    join
    wait_idle();
    check("timeout_pulses", tcount - t0, 1);

    // UDP tx_en held for 2000 cycles
    o0 = ocount;
    base = vtotal;
    count_only = 1'b1;
    agent(2, 2000, 0, 1'b0, 1'b0, h2);
    wait_idle();
    count_only = 1'b0;
    check("overlong_valid_cycles", vtotal - base, MAXLEN);
    check("overlong_pulses", ocount - o0, 1);
    check("overlong_busy", int'(busy), 0);

    // reset in the middle of a frame
    fork
      agent(2, 40, 0, 1'b0, 1'b1, h2);
      begin
        base = vtotal;
        n = 0;
        tick();
        while (vtotal - base < 20 && n < 500) begin tick(); n++; end
        check("reset_wait_bound", int'(n < 500), 1);
        mon_en = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("reset_async_valid", int'(gmii_txd_valid), 0);
        check("reset_async_gnt", int'(gnt_v), 0);
        abort = 1'b1;
        tick();
        tick();
      end
    join
    abort = 1'b0;
    exp_d.delete();
    exp_c.delete();
    fork
      agent(0, 12, 0, 1'b0, 1'b1, h0);
      begin
        #2;
        resetn = 1'b1;
        mon_en = 1'b1;
        tick();
        check("reset_arp_gnt", int'(arp_gnt), 1);
      end
    join
    wait_idle();

    // randomized request mixes
    for (int r = 0; r < 15; r++) begin
      bit [2:0] en;
      int l0, l1, l2, d0, d1, d2;
      en = 3'($urandom_range(1, 7));
      l0 = $urandom_range(1, 24); l1 = $urandom_range(1, 24); l2 = $urandom_range(1, 24);
      d0 = $urandom_range(0, 20); d1 = $urandom_range(0, 20); d2 = $urandom_range(0, 20);
      fork
        if (en[0]) agent(0, l0, d0, 1'b0, 1'b1, h0);
        if (en[1]) agent(1, l1, d1, 1'b0, 1'b1, h1);
        if (en[2]) agent(2, l2, d2, 1'b0, 1'b1, h2);
      join
      wait_idle();
    end

    check("queue_drained", exp_d.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
